// File: rtl/glm_dot_pack_if.sv
// ============================================================================
// Module      : fifobram_interface
// Description : Generic FIFO-read / BRAM-write bundle. One instance carries
//               either a FIFO read port (re, rvalid, rdata, empty) or a BRAM
//               write port (we, waddr, wdata); the modport picks the role.
//               DATA_W sets both rdata and wdata width, ADDR_W sets waddr.
// Modports    : fifo_read  - reader side of a FIFO (drives re)
//               fifo_src   - FIFO side (drives rvalid/rdata/empty)
//               bram_write - writer side of a BRAM (drives we/waddr/wdata)
//               bram_sink  - BRAM side (observes the write)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifobram_interface #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  // FIFO read channel
  logic              re;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              empty;
  // BRAM write channel
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  modport fifo_read  (output re, input rvalid, input rdata, input empty);
  modport fifo_src   (input re, output rvalid, output rdata, output empty);
  modport bram_write (output we, output waddr, output wdata);
  modport bram_sink  (input we, input waddr, input wdata);
endinterface

`default_nettype wire

// File: rtl/glm_dot_pack.sv
// ============================================================================
// Module      : glm_dot_pack
// Description : Collects a stream of 32-bit scalar dot results from a FIFO
//               and packs them sixteen at a time into 512-bit lines written to
//               a line memory, starting at a programmable line address.
// Ports       : clk       - single clock
//               resetn    - asynchronous active-low reset
//               op_start  - one-cycle start pulse (honoured only when idle)
//               op_done   - one-cycle completion pulse
//               regs[0:5] - instruction registers, sampled on op_start
//                           regs[3][15:0] = num_values, regs[4][15:0] = store_offset
//               FIFO_dot  - 32-bit FIFO read port (source of scalars)
//               MEM_dots  - 512-bit / 16-bit-address write port (packed lines)
// Config      : GLM_DOT_PACK_ZERO_PAD_EN - when defined, unfilled lanes of a
//               partial final line are written as zero; otherwise they carry
//               stale line-register contents.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module glm_dot_pack (
  input  wire logic        clk,
  input  wire logic        resetn,
  input  wire logic        op_start,
  output logic             op_done,
  input  wire logic [31:0] regs [0:5],
  fifobram_interface.fifo_read  FIFO_dot,
  fifobram_interface.bram_write MEM_dots
);

`ifdef GLM_DOT_PACK_ZERO_PAD_EN
  localparam bit c_ZERO_PAD = 1'b1;
`else
  localparam bit c_ZERO_PAD = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PACK  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic [15:0]  r_num_values;
  logic [15:0]  r_store_offset;
  logic [15:0]  r_requested;
  logic [15:0]  r_received;
  logic [15:0]  r_line;

  logic         r_re;
  logic         r_we;
  logic         r_op_done;
  logic [15:0]  r_waddr;
  logic [511:0] r_wdata;
  logic [511:0] r_line_buf;

  logic         w_re_nxt;
  logic         w_we_nxt;
  logic         w_op_done_nxt;
  logic [3:0]   w_lane;
  logic         w_last;
  logic         w_accept;

  // Only the two decoded 16-bit fields are consumed.
  logic         w_unused_regs;
  assign w_unused_regs = ^{regs[0], regs[1], regs[2], regs[3][31:16],
                           regs[4][31:16], regs[5]};

  assign w_lane   = r_received[3:0];
  assign w_last   = ((r_received + 16'd1) == r_num_values);
  assign w_accept = (r_state == S_PACK) && FIFO_dot.rvalid;

  assign FIFO_dot.re    = r_re;
  assign MEM_dots.we    = r_we;
  assign MEM_dots.waddr = r_waddr;
  assign MEM_dots.wdata = r_wdata;
  assign op_done        = r_op_done;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and next values of the registered control outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_re_nxt      = 1'b0;
    w_we_nxt      = 1'b0;
    w_op_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (op_start) begin
          // An empty operation completes immediately without touching memory.
          if (regs[3][15:0] == 16'd0) begin
            w_op_done_nxt = 1'b1;
          end else begin
            w_state_nxt = S_PACK;
          end
        end
      end
      S_PACK: begin
        // Reads are spaced at least one cycle apart so that the FIFO's
        // empty flag has caught up with the previous pop before the next one.
        w_re_nxt = !r_re && !FIFO_dot.empty && (r_requested < r_num_values);
        if (FIFO_dot.rvalid) begin
          if (w_lane == 4'hF) begin
            w_we_nxt = 1'b1;
          end
          if (w_last) begin
            w_state_nxt = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        // r_we high here means the final value completed a full line and its
        // write is on the bus now; otherwise the partial line still needs
        // writing, and completion follows on the cycle after that write.
        if (r_we) begin
          w_op_done_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end else begin
          w_we_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Control outputs and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_re           <= 1'b0;
      r_we           <= 1'b0;
      r_op_done      <= 1'b0;
      r_num_values   <= 16'd0;
      r_store_offset <= 16'd0;
      r_requested    <= 16'd0;
      r_received     <= 16'd0;
      r_line         <= 16'd0;
      r_waddr        <= 16'd0;
      r_wdata        <= '0;
      r_line_buf     <= '0;
    end else begin
      r_re      <= w_re_nxt;
      r_we      <= w_we_nxt;
      r_op_done <= w_op_done_nxt;

      if ((r_state == S_IDLE) && op_start) begin
        r_num_values   <= regs[3][15:0];
        r_store_offset <= regs[4][15:0];
        r_requested    <= 16'd0;
        r_received     <= 16'd0;
        r_line         <= 16'd0;
        if (c_ZERO_PAD) begin
          r_line_buf <= '0;
        end
      end

      if ((r_state == S_PACK) && w_re_nxt) begin
        r_requested <= r_requested + 16'd1;
      end

      if (w_accept) begin
        r_received <= r_received + 16'd1;
        if (w_lane == 4'hF) begin
          // Lane 15 completes the line: the write data is assembled directly
          // so the buffer is free for lane 0 of the next line on the very
          // next cycle.
          r_wdata <= {FIFO_dot.rdata, r_line_buf[479:0]};
          r_waddr <= r_store_offset + r_line;
          r_line  <= r_line + 16'd1;
          if (c_ZERO_PAD) begin
            r_line_buf <= '0;
          end else begin
            r_line_buf[511:480] <= FIFO_dot.rdata;
          end
        end else begin
          r_line_buf[{w_lane, 5'd0} +: 32] <= FIFO_dot.rdata;
        end
      end

      // Partial final line.
      if ((r_state == S_FLUSH) && !r_we) begin
        r_wdata <= r_line_buf;
        r_waddr <= r_store_offset + r_line;
        r_line  <= r_line + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/glm_dot_pack.md
GLM_DOT_PACK -- requirements
Module: glm_dot_pack

Interface
REQ-001 SHALL have port clk, input, 1, single clock for all logic.
REQ-002 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port op_start, input, 1, one-cycle pulse that starts an operation when the block is idle.
REQ-004 SHALL have port op_done, output, 1, one-cycle pulse when the operation completes.
REQ-005 SHALL have port regs, input, 6 x 32, instruction registers sampled on op_start.
REQ-006 SHALL have port FIFO_dot, fifobram_interface.fifo_read, 32-bit data (re, rvalid, rdata, empty), source of scalar dot results.
REQ-007 SHALL have port MEM_dots, fifobram_interface.bram_write, 512-bit data, 16-bit address (we, waddr, wdata), destination of packed lines.
REQ-008 SHALL decode field num_values = regs[3][15:0], default 0, number of 32-bit values to pack.
REQ-009 SHALL decode field store_offset = regs[4][15:0], default 0, MEM_dots line address of the first packed line.

Function
REQ-010 SHALL implement states IDLE, PACK and FLUSH; IDLE -> PACK on op_start; PACK -> FLUSH when the final value is received; FLUSH -> IDLE after the final line write.
REQ-011 SHALL ignore op_start outside IDLE.
REQ-012 SHALL latch num_values and store_offset on op_start and clear the requested, received and line counters (16-bit each).
REQ-013 SHALL drive FIFO_dot.re as a registered one-cycle pulse in PACK only when !FIFO_dot.empty and requested < num_values, incrementing requested on each pulse.
REQ-014 SHALL treat every FIFO_dot.rvalid cycle in PACK as one value and place rdata into lane received[3:0], where lane 0 = bits [31:0] and lane 15 = bits [511:480].
REQ-015 SHALL issue one MEM_dots write, registered one cycle after lane 15 is filled, with waddr = store_offset + line (16-bit wrap-around) and line incremented afterwards.
REQ-016 SHALL, when received reaches num_values with a partially filled line, issue one final write of that line in FLUSH; if the last line is full, SHALL issue no extra write.
REQ-017 SHALL write exactly ceil(num_values/16) lines per operation.
REQ-018 SHALL assert op_done for exactly one cycle, one cycle after the final MEM_dots write.
REQ-019 SHALL, when num_values = 0, issue no reads and no writes and pulse op_done on the cycle after op_start.
REQ-020 SHALL ignore FIFO_dot.rvalid outside PACK, and SHALL NOT stall when rvalid arrives in the same cycle as a line write; a new line starts in lane 0 without loss.
REQ-021 SHALL keep MEM_dots.we and FIFO_dot.re low in IDLE.

Reset
REQ-022 SHALL, on resetn low at any time, including mid-operation, enter IDLE asynchronously and drive op_done, FIFO_dot.re and MEM_dots.we to 0, with all counters and waddr at 0.
REQ-023 SHALL NOT pulse op_done for an operation interrupted by reset, and SHALL accept op_start on the first cycle after resetn rises.

Configuration
REQ-024 SHALL honour macro GLM_DOT_PACK_ZERO_PAD_EN: when defined, unfilled lanes of a partial final line SHALL be written as 32'h0; when undefined, those lanes SHALL hold whatever values the line register last contained, and the bench treats them as don't-care.

Verification
REQ-025 SHALL pass this scenario: num_values=16, offset=0x10, values 1..16 -> one write to addr 0x10, lane i = i+1, op_done one cycle later.
REQ-026 SHALL pass this scenario: num_values=35, offset=0 -> writes to addr 0, 1 and 2; line 2 lanes 0-2 = values 33-35; with ZERO_PAD_EN, lanes 3-15 = 0.
REQ-027 SHALL pass this scenario: num_values=0 -> no re and no we, op_done on the cycle after op_start.
REQ-028 SHALL pass this scenario: num_values=32 with FIFO_dot.empty toggling every 3 cycles -> exactly 32 re pulses, 2 writes, data in order.
REQ-029 SHALL pass this scenario: offset=0xFFFF, num_values=32 -> waddr 0xFFFF then 0x0000.
REQ-030 SHALL pass this scenario: resetn low after 20 of 40 values are received -> outputs 0 and no op_done; a new op with num_values=16 then completes normally.
